// File: rtl/result_display_ctrl_pkg.sv
// Shared types and constants for the result display controller: FSM states,
// seven-segment glyphs (active-low {a,b,c,d,e,f,g}) and element indices.
package result_display_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      SHOW = 2'd2
   } state_e;

   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] IDX_C00 = 2'd0;
   localparam logic [1:0] IDX_C01 = 2'd1;
   localparam logic [1:0] IDX_C10 = 2'd2;
   localparam logic [1:0] IDX_C11 = 2'd3;

   // 16-entry hex-to-segment table, active-low.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         4'hF:    s = 7'b0111000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // Number of decimal digits needed for the largest w-bit unsigned value.
   function automatic int bcd_digits(input int w);
      int unsigned max_v;
      int          n;
      max_v = (32'd1 << w) - 32'd1;
      n     = 1;
      while (max_v >= 32'd10) begin
         max_v = max_v / 32'd10;
         n     = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/result_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: start loads the operand, one shift per cycle,
// valid rises after exactly RES_W shifts and holds until the next start.
module bin2bcd_seq
   import result_display_ctrl_pkg::*;
#(
   parameter int RES_W = 8,
   parameter int NDIG  = bcd_digits(RES_W)
) (
   input  logic                clk,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [RES_W-1:0]    bin_i,
   output logic                busy_o,
   output logic                valid_o,
   output logic [4*NDIG-1:0]   bcd_o
);

   localparam int BCD_W = 4 * NDIG;
   localparam int CNT_W = $clog2(RES_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);

   logic [RES_W-1:0] bin_q, bin_d, bin_sh_s;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_sh_s, adj_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;

   // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one.
   always_comb begin
      adj_s = bcd_q;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
      {bcd_sh_s, bin_sh_s} = {adj_s, bin_q} << 1'b1;
   end

   // Load / step / finish control.
   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      if (start_i) begin
         bin_d   = bin_i;
         bcd_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b1;
         valid_d = 1'b0;
      end else if (busy_q) begin
         bin_d = bin_sh_s;
         bcd_d = bcd_sh_s;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end else begin
            busy_d  = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign bcd_o   = bcd_q;

endmodule

// File: rtl/result_display_ctrl.sv
// Button-driven selection of one 2x2 result element, BCD conversion and
// 4-digit multiplexed seven-segment display with leading-zero blanking.
module result_display_ctrl
   import result_display_ctrl_pkg::*;
#(
   parameter int RES_W       = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               done,
   input  logic [4*RES_W-1:0] res_flat,
   input  logic               up_clean,
   input  logic               left_clean,
   input  logic               right_clean,
   input  logic               down_clean,
   output logic               conv_done,
   output logic [1:0]         sel_idx,
   output logic [3:0]         anode,
   output logic [6:0]         seg,
   output logic               dp
);

   localparam int NDIG   = bcd_digits(RES_W);
   localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

   logic [3:0]        btn_s, btn_q, edge_s;
   logic              edge_any_s;
   logic [1:0]        edge_idx_s;
   logic [RES_W-1:0]  conv_bin_s;
   logic              conv_start_s;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic              conv_done_q, conv_done_d;
   logic [11:0]       disp_q, disp_d;

   logic [4*NDIG-1:0] bcd_s;
   logic              bcd_busy_s, bcd_valid_s;

   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        digit_q, digit_d;
   logic [3:0]        anode_q, anode_d;
   logic [6:0]        seg_q, glyph_s;
   logic              dp_q, dp_s;

   // Bit order matches element index: up=C00, left=C01, right=C10, down=C11.
   assign btn_s      = {down_clean, right_clean, left_clean, up_clean};
   assign edge_s     = btn_s & ~btn_q;
   assign edge_any_s = |edge_s;

   // Priority pick of simultaneous edges and the matching result slice.
   always_comb begin
      if (edge_s[0]) begin
         edge_idx_s = IDX_C00;
      end else if (edge_s[1]) begin
         edge_idx_s = IDX_C01;
      end else if (edge_s[2]) begin
         edge_idx_s = IDX_C10;
      end else begin
         edge_idx_s = IDX_C11;
      end
      case (edge_idx_s)
         IDX_C00: conv_bin_s = res_flat[0*RES_W +: RES_W];
         IDX_C01: conv_bin_s = res_flat[1*RES_W +: RES_W];
         IDX_C10: conv_bin_s = res_flat[2*RES_W +: RES_W];
         IDX_C11: conv_bin_s = res_flat[3*RES_W +: RES_W];
         default: conv_bin_s = '0;
      endcase
   end

   bin2bcd_seq #(
      .RES_W (RES_W),
      .NDIG  (NDIG)
   ) u_bin2bcd (
      .clk     (clk),
      .rst_ni  (rst),
      .start_i (conv_start_s),
      .bin_i   (conv_bin_s),
      .busy_o  (bcd_busy_s),
      .valid_o (bcd_valid_s),
      .bcd_o   (bcd_s)
   );

   // Next state: done low forces IDLE and swallows any edge in that cycle.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      conv_done_d  = conv_done_q;
      disp_d       = disp_q;
      conv_start_s = 1'b0;
      if (!done) begin
         state_d     = IDLE;
         conv_done_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, SHOW: begin
               if (edge_any_s) begin
                  state_d      = CONV;
                  sel_d        = edge_idx_s;
                  conv_start_s = 1'b1;
                  conv_done_d  = 1'b0;
               end else begin
                  state_d = state_q;
               end
            end
            CONV: begin
               if (bcd_valid_s && !bcd_busy_s) begin
                  state_d     = SHOW;
                  disp_d      = 12'(bcd_s);
                  conv_done_d = 1'b1;
               end else begin
                  state_d = CONV;
               end
            end
            default: begin
               state_d     = IDLE;
               conv_done_d = 1'b0;
            end
         endcase
      end
   end

   // Glyph for the digit being scanned; only SHOW displays real content.
   always_comb begin
      glyph_s = SEG_DASH;
      dp_s    = 1'b1;
      if (state_q == SHOW) begin
         case (digit_q)
            2'd3: begin
               glyph_s = hex_to_seg({2'b00, sel_q});
               dp_s    = 1'b0;
            end
            2'd2: glyph_s = (disp_q[11:8] == 4'd0) ? SEG_BLANK : hex_to_seg(disp_q[11:8]);
            2'd1: glyph_s = (disp_q[11:4] == 8'd0) ? SEG_BLANK : hex_to_seg(disp_q[7:4]);
            2'd0: glyph_s = hex_to_seg(disp_q[3:0]);
            default: glyph_s = SEG_DASH;
         endcase
      end else begin
         glyph_s = SEG_DASH;
      end
   end

   // Free-running scan divider and digit pointer.
   always_comb begin
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         digit_d    = digit_q + 2'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
         digit_d    = digit_q;
      end
      anode_d = ~(4'b0001 << digit_q);
   end

   // Edge sampling, FSM and data registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q       <= 4'b0000;
         state_q     <= IDLE;
         sel_q       <= IDX_C00;
         conv_done_q <= 1'b0;
         disp_q      <= 12'h000;
      end else begin
         btn_q       <= btn_s;
         state_q     <= state_d;
         sel_q       <= sel_d;
         conv_done_q <= conv_done_d;
         disp_q      <= disp_d;
      end
   end

   // Scan counter and display outputs; anode, seg and dp update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt_q <= '0;
         digit_q    <= 2'd0;
         anode_q    <= 4'b1110;
         seg_q      <= SEG_DASH;
         dp_q       <= 1'b1;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
         anode_q    <= anode_d;
         seg_q      <= glyph_s;
         dp_q       <= dp_s;
      end
   end

   assign conv_done = conv_done_q;
   assign sel_idx   = sel_q;
   assign anode     = anode_q;
   assign seg       = seg_q;
   assign dp        = dp_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Self-checking bench for result_display_ctrl: table vectors, hand-written
// corner sequences and randomized presses against a decimal-arithmetic model.
module tb_result_display_ctrl;

   localparam int RES_W       = 8;
   localparam int REFRESH_DIV = 4;
   localparam logic [6:0] DASH  = 7'b1111110;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               done = 1'b0;
   logic [4*RES_W-1:0] res_flat = '0;
   logic               up_clean = 1'b0, left_clean = 1'b0;
   logic               right_clean = 1'b0, down_clean = 1'b0;
   logic               conv_done;
   logic [1:0]         sel_idx;
   logic [3:0]         anode;
   logic [6:0]         seg;
   logic               dp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] mask;   // {down,right,left,up}
      int         v[4];
      int         sel;
      int         dig[4]; // dig[d] for anode bit d, -1 = blank
   } vec_t;

   vec_t tab[10];
   int   cur_vals[4];
   int   cur_dig[4];
   logic [6:0] rd_seg[4];
   logic       rd_dp[4];
   bit         rd_seen[4];
   bit         rd_bad;

   always #5 clk = ~clk;

   result_display_ctrl #(
      .RES_W       (RES_W),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .done        (done),
      .res_flat    (res_flat),
      .up_clean    (up_clean),
      .left_clean  (left_clean),
      .right_clean (right_clean),
      .down_clean  (down_clean),
      .conv_done   (conv_done),
      .sel_idx     (sel_idx),
      .anode       (anode),
      .seg         (seg),
      .dp          (dp)
   );

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0:  return 7'b0000001;
         1:  return 7'b1001111;
         2:  return 7'b0010010;
         3:  return 7'b0000110;
         4:  return 7'b1001100;
         5:  return 7'b0100100;
         6:  return 7'b0100000;
         7:  return 7'b0001111;
         8:  return 7'b0000000;
         9:  return 7'b0000100;
         default: return BLANK;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_vec(input int i, input logic [3:0] m, input int v0, input int v1,
                          input int v2, input int v3, input int s, input int d3,
                          input int d2, input int d1, input int d0);
      tab[i].mask = m;
      tab[i].v[0] = v0; tab[i].v[1] = v1; tab[i].v[2] = v2; tab[i].v[3] = v3;
      tab[i].sel  = s;
      tab[i].dig[3] = d3; tab[i].dig[2] = d2; tab[i].dig[1] = d1; tab[i].dig[0] = d0;
   endtask

   task automatic drive_vals();
      for (int i = 0; i < 4; i++) begin
         res_flat[i*RES_W +: RES_W] = RES_W'(cur_vals[i]);
      end
   endtask

   task automatic read_display();
      int idx;
      rd_bad = 1'b0;
      for (int d = 0; d < 4; d++) rd_seen[d] = 1'b0;
      for (int c = 0; c < 4*REFRESH_DIV; c++) begin
         @(negedge clk);
         case (anode)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         if (idx < 0) begin
            rd_bad = 1'b1;
         end else begin
            rd_seg[idx]  = seg;
            rd_dp[idx]   = dp;
            rd_seen[idx] = 1'b1;
         end
      end
   endtask

   task automatic check_display(input string tag, input bit dashes);
      read_display();
      check($sformatf("%s_anode_onehot", tag), int'(rd_bad), 0);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s_seen%0d", tag, d), int'(rd_seen[d]), 1);
         check($sformatf("%s_seg%0d", tag, d), int'(rd_seg[d]),
               dashes ? int'(DASH) : int'(glyph(cur_dig[d])));
         check($sformatf("%s_dp%0d", tag, d), int'(rd_dp[d]), (!dashes && d == 3) ? 0 : 1);
      end
   endtask

   // Press buttons for one cycle; returns right after the edge-sampling clock.
   task automatic press(input logic [3:0] mask);
      @(negedge clk);
      {down_clean, right_clean, left_clean, up_clean} = mask;
      @(negedge clk);
      {down_clean, right_clean, left_clean, up_clean} = 4'b0000;
   endtask

   task automatic wait_conv(input string tag, input int first_k);
      int k;
      k = first_k;
      while (conv_done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("%s_latency", tag), k, RES_W + 1);
   endtask

   task automatic run_conv(input string tag, input logic [3:0] mask, input int e_sel);
      drive_vals();
      press(mask);
      check($sformatf("%s_drop", tag), int'(conv_done), 0);
      check($sformatf("%s_sel", tag), int'(sel_idx), e_sel);
      wait_conv(tag, 0);
      check_display(tag, 1'b0);
   endtask

   // Reference model: priority pick and decimal digits with blanking.
   task automatic model(input logic [3:0] mask, output int e_sel);
      int v, h, t;
      bit found;
      found = 1'b0;
      e_sel = 3;
      for (int b = 0; b < 4; b++) begin
         if (mask[b] && !found) begin
            e_sel = b;
            found = 1'b1;
         end
      end
      v = cur_vals[e_sel];
      h = v / 100;
      t = (v / 10) % 10;
      cur_dig[3] = e_sel;
      cur_dig[2] = (h == 0) ? -1 : h;
      cur_dig[1] = (h == 0 && t == 0) ? -1 : t;
      cur_dig[0] = v % 10;
   endtask

   task automatic check_reset_outputs(input string tag);
      check($sformatf("%s_conv_done", tag), int'(conv_done), 0);
      check($sformatf("%s_sel", tag), int'(sel_idx), 0);
      check($sformatf("%s_anode", tag), int'(anode), 4'b1110);
      check($sformatf("%s_seg", tag), int'(seg), int'(DASH));
      check($sformatf("%s_dp", tag), int'(dp), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] prev, m;
      int run, bad, changes, e_sel;

      set_vec(0, 4'b0001,  18,   0,  0,   0, 0, 0, -1,  1, 8);
      set_vec(1, 4'b1000,  18,   0,  0, 255, 3, 3,  2,  5, 5);
      set_vec(2, 4'b0100,  18,   0,  7, 255, 2, 2, -1, -1, 7);
      set_vec(3, 4'b1001,   5,   0,  7,   9, 0, 0, -1, -1, 5);
      set_vec(4, 4'b0010,   5, 100,  7,   9, 1, 1,  1,  0, 0);
      set_vec(5, 4'b0010,   5,   0,  7,   9, 1, 1, -1, -1, 0);
      set_vec(6, 4'b0110,   5, 209, 50,   9, 1, 1,  2,  0, 9);
      set_vec(7, 4'b1100,   5, 209, 50, 105, 2, 2, -1,  5, 0);
      set_vec(8, 4'b1000,   5, 209, 50, 105, 3, 3,  1,  0, 5);
      set_vec(9, 4'b1111,  99, 209, 50, 105, 0, 0, -1,  9, 9);

      // Reset state held, then release.
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b1;

      // done low: edges ignored, dashes, scan order and dwell.
      press(4'b0001);
      repeat (15) @(negedge clk);
      check("idle_no_conv", int'(conv_done), 0);
      prev = anode; run = 0; bad = 0; changes = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (anode == prev) begin
            run++;
         end else begin
            if (anode != {prev[2:0], prev[3]}) bad++;
            if (changes > 0 && run != REFRESH_DIV) bad++;
            changes++;
            run  = 1;
            prev = anode;
         end
      end
      check("scan_order_dwell", bad, 0);
      check("scan_advances", int'(changes >= 5), 1);
      check_display("idle_dash", 1'b1);

      // Table-driven conversions.
      done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            cur_vals[j] = tab[i].v[j];
            cur_dig[j]  = tab[i].dig[j];
         end
         run_conv($sformatf("vec%0d", i), tab[i].mask, tab[i].sel);
      end

      // Edge during CONV is dropped.
      cur_vals[0] = 5; cur_vals[1] = 100; cur_vals[2] = 7; cur_vals[3] = 9;
      drive_vals();
      press(4'b0010);
      repeat (2) @(negedge clk);
      right_clean = 1'b1;
      @(negedge clk);
      right_clean = 1'b0;
      wait_conv("drop_edge", 3);
      check("drop_edge_sel", int'(sel_idx), 1);
      cur_dig[3] = 1; cur_dig[2] = 1; cur_dig[1] = 0; cur_dig[0] = 0;
      check_display("drop_edge", 1'b0);
      repeat (12) @(negedge clk);
      check("drop_edge_no_requeue", int'(conv_done), 1);
      check("drop_edge_sel_kept", int'(sel_idx), 1);

      // done falls mid-CONV.
      cur_vals[3] = 42;
      drive_vals();
      press(4'b1000);
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      check("abort_conv_done", int'(conv_done), 0);
      check("abort_sel_kept", int'(sel_idx), 3);
      repeat (15) @(negedge clk);
      check("abort_stays_idle", int'(conv_done), 0);
      check_display("abort_dash", 1'b1);
      done = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_needs_edge", int'(conv_done), 0);

      // done falls in SHOW together with an edge.
      cur_vals[2] = 137;
      model(4'b0100, e_sel);
      run_conv("pre_fall", 4'b0100, e_sel);
      @(negedge clk);
      done = 1'b0;
      up_clean = 1'b1;
      @(negedge clk);
      check("fall_conv_done", int'(conv_done), 0);
      check("fall_sel_kept", int'(sel_idx), 2);
      up_clean = 1'b0;
      done = 1'b1;
      repeat (14) @(negedge clk);
      check("fall_edge_ignored", int'(conv_done), 0);

      // Randomized presses against the model.
      for (int it = 0; it < 20; it++) begin
         for (int j = 0; j < 4; j++) begin
            cur_vals[j] = ((it + j) % 3 == 0) ? int'($urandom_range(0, 12))
                                              : int'($urandom_range(0, 255));
         end
         m = 4'($urandom_range(1, 15));
         model(m, e_sel);
         run_conv($sformatf("rnd%0d", it), m, e_sel);
      end

      // Asynchronous reset while in SHOW.
      cur_vals[1] = 64;
      model(4'b0010, e_sel);
      run_conv("pre_rst", 4'b0010, e_sel);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_conv_done", int'(conv_done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Downstream stage of the matrix multiply/accumulate FSM. Once the FSM signals done, the four debounced direction buttons select one element of the 2x2 result matrix C.
- The selected value is converted to BCD with a sequential double-dabble and shown on the 4-digit multiplexed seven-segment display.
- conv_done tells the rest of the design, and the bench, that the displayed value is valid.

Parameters:
- RES_W, 8, width of one result element. Legal range 4..9, so the value always fits in 3 BCD digits.
- REFRESH_DIV, 100000, clock cycles each digit is driven before the scan advances. Benches use 4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Asynchronous and active-low.
- done  in  1  level from the accumulator FSM; the C results are valid while high
- res_flat  in  4*RES_W  C00 at [RES_W-1:0], then C01, then C10, with C11 in the top slice
- up_clean, left_clean, right_clean, down_clean  in  1 each  debounced button levels
- conv_done  out  1  high while the display holds a valid converted value
- sel_idx  out  2  currently selected element: 0=C00, 1=C01, 2=C10, 3=C11
- anode  out  4  digit enables, active-low; anode[0] is the rightmost digit
- seg  out  7  segments in {a,b,c,d,e,f,g} order, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset values: conv_done=0, sel_idx=0, anode=4'b1110, seg=7'b1111110 (dash), dp=1, state=IDLE, scan counter=0.
- Button edges:
  - Each button level is registered once; a rising edge is level=1 while the previous sample is 0.
  - Mapping: up selects C00, left C01, right C10, down C11.
  - When several edges occur in the same cycle, priority is up > left > right > down.
- States are IDLE, CONV and SHOW.
- IDLE:
  - All four digits show a dash and conv_done=0.
  - Edges are ignored while done=0.
  - An edge seen with done=1 moves to CONV.
- Entering CONV (the cycle the edge is seen):
  - sel_idx updates.
  - The selected slice is latched into the shift register and the BCD register is cleared.
  - conv_done drops to 0 and the bit counter is set to 0.
- CONV:
  - Each cycle applies add-3 to every BCD nibble that is >=5, then shifts {bcd,bin} left by one.
  - After exactly RES_W cycles, the BCD result is copied into the display register, conv_done goes to 1, and the state moves to SHOW.
  - Latency: conv_done is high at the (RES_W+1)th rising edge after the edge-sampling edge, which is 9 for RES_W=8.
  - Edges arriving during CONV are dropped, not queued.
- SHOW:
  - conv_done stays high.
  - A new edge restarts CONV, dropping conv_done for RES_W+1 cycles.
  - Pressing the same button again re-converts the same element.
- done falling in any state:
  - The next state is IDLE, conv_done goes to 0, and the digits show dashes.
  - sel_idx is retained.
  - An edge arriving in that same cycle is ignored.
- Digit contents in SHOW:
  - Digit3 shows sel_idx as a hex glyph with dp lit; dp is off for all other digits.
  - Digits 2..0 show hundreds, tens and ones.
  - Leading zeros are blanked in hundreds, and in tens when hundreds is 0. Ones is never blanked.
  - Blank is 7'b1111111.
- Scan:
  - A free-running counter rolls over every REFRESH_DIV cycles and then advances the digit 0,1,2,3,0.
  - Exactly one anode is low at a time, and seg/dp are registered together with anode.
  - The scan runs in every state.
- Reset asserted mid-CONV or SHOW: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Shared package contents:
  - State enum (IDLE/CONV/SHOW).
  - SEG_DASH and SEG_BLANK constants and the 16-entry hex-to-segment table.
  - Element index constants IDX_C00..IDX_C11.
  - Function computing the BCD digit count from RES_W.
- Sub-module bin2bcd_seq: a start/busy/valid double-dabble parameterised by RES_W.
- This top holds the edge detect, FSM, blanking and scan.

Test Plan:
- Reset, then hold with done=0 and pulse up_clean: conv_done stays 0 and all digits remain dash with anode cycling 1110, 1101, 1011, 0111 at REFRESH_DIV=4.
- done=1, C00=18, pulse up: conv_done rises 9 cycles after the edge sample; digits read "0." blank 1 8; sel_idx=0.
- C11=255, pulse down: digits "3." 2 5 5. Then C10=7 and pulse right: digits "2." blank blank 7.
- Pulse up and down in the same cycle with C00=5 and C11=9: sel_idx=0 and the display shows 5.
- Start left (C01=100) and press right on the 4th CONV cycle: ignored; after completion the display shows "1." 1 0 0.
- Drop done mid-CONV: next cycle IDLE with dashes and conv_done=0. Assert rst in SHOW: outputs take reset values asynchronously.
